// File: rtl/alu_exec_if.sv
// alu_exec_if: controller-to-execute-unit bus (request, operands, result, handshake)
interface alu_exec_if #(parameter int WIDTH = 16);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a_data;
    logic [WIDTH-1:0] b_data;
    logic [WIDTH-1:0] result;
    logic [2:0]       flag;
    logic             busy;
    logic             done;
    modport master (output start, op, a_data, b_data, input result, flag, busy, done);
    modport slave  (input start, op, a_data, b_data, output result, flag, busy, done);
endinterface

// File: rtl/alu_exec.sv
// alu_exec: multi-cycle 16-bit ALU with {C,N,Z} flags; iterative multiply built when ALU_MUL_EN is defined
module alu_exec #(parameter int WIDTH = 16) (
    input logic       CLK,
    input logic       RST,
    alu_exec_if.slave bus
);
`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif
    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d, res;
    logic [2:0]       flag_q, flag_d;
    logic             done_q, done_d, c;
    logic [WIDTH:0]   sum_w, diff_w, shl_w, shr_w;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc_q, acc_d, pp;
    logic [3:0]         cnt_q, cnt_d;
`endif
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flag_d   = flag_q;
        done_d   = 1'b0;
        res      = '0;
        c        = 1'b0;
        sum_w    = {1'b0, a_q} + {1'b0, b_q};
        diff_w   = {1'b0, a_q} - {1'b0, b_q};
        shl_w    = {1'b0, a_q} << b_q[3:0];
        shr_w    = {a_q, 1'b0} >> b_q[3:0];
`ifdef ALU_MUL_EN
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        pp       = {{WIDTH{1'b0}}, a_q} << cnt_q;
`endif
        case (op_q)
            4'd0: {c, res} = sum_w;
            4'd1: {c, res} = diff_w;
            4'd2: res = a_q & b_q;
            4'd3: res = a_q | b_q;
            4'd4: res = a_q ^ b_q;
            4'd5: res = ~a_q;
            4'd6: {c, res} = shl_w;
            4'd7: {res, c} = shr_w;
            4'd8: res = b_q;
`ifdef ALU_MUL_EN
            4'd9: begin
                res = acc_q[WIDTH-1:0];
                c   = |acc_q[2*WIDTH-1:WIDTH];
            end
`endif
            default: res = '0;
        endcase
        case (state_q)
            IDLE: if (bus.start) begin
                op_d = bus.op;
                a_d  = bus.a_data;
                b_d  = bus.b_data;
`ifdef ALU_MUL_EN
                acc_d   = '0;
                cnt_d   = '0;
                state_d = (bus.op == 4'd9) ? MUL : EXEC;
`else
                state_d = EXEC;
`endif
            end
            EXEC: begin
                result_d = res;
                flag_d   = {c, res[WIDTH-1], res == '0};
                done_d   = 1'b1;
                state_d  = IDLE;
            end
`ifdef ALU_MUL_EN
            // Last iteration hands off to EXEC, which registers the product like any other op.
            MUL: begin
                acc_d   = acc_q + (b_q[cnt_q] ? pp : '0);
                cnt_d   = cnt_q + 4'd1;
                state_d = (cnt_q == 4'd15) ? EXEC : MUL;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flag_q   <= '0;
            done_q   <= 1'b0;
`ifdef ALU_MUL_EN
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            done_q   <= done_d;
`ifdef ALU_MUL_EN
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end
    assign bus.result = result_q;
    assign bus.flag   = flag_q;
    assign bus.busy   = state_q != IDLE;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: randomized self-checking bench for alu_exec against an arithmetic reference model
module tb_alu_exec;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;
    alu_exec_if bus ();
    alu_exec dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // returns {C, N, Z, result}
    function automatic logic [18:0] model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] x;
        logic [15:0] r;
        logic        cy;
        int          n;
        n  = int'(b[3:0]);
        x  = 32'd0;
        r  = 16'd0;
        cy = 1'b0;
        case (o)
            4'd0: begin x = 32'(a) + 32'(b); r = x[15:0]; cy = x > 32'd65535; end
            4'd1: begin r = a - b; cy = a < b; end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin x = 32'(a) << n; r = x[15:0]; cy = x[16]; end
            4'd7: begin x = (32'(a) << 1) >> n; r = x[16:1]; cy = x[0]; end
            4'd8: r = b;
            4'd9: if (MUL_EN) begin x = 32'(a) * 32'(b); r = x[15:0]; cy = x[31:16] != 16'd0; end
            default: r = 16'd0;
        endcase
        return {cy, r[15], r == 16'd0, r};
    endfunction

    function automatic int exp_lat(input logic [3:0] o);
        return (o == 4'd9 && MUL_EN) ? 17 : 1;
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [18:0] e;
        int lat;
        e = model(o, a, b);
        @(negedge CLK);
        bus.start = 1'b1; bus.op = o; bus.a_data = a; bus.b_data = b;
        @(posedge CLK); #1;
        bus.start = 1'b0; bus.op = 4'($urandom); bus.a_data = 16'($urandom); bus.b_data = 16'($urandom);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        check($sformatf("latency op%0d", o), lat, exp_lat(o));
        check($sformatf("result op%0d a%h b%h", o, a, b), 32'(bus.result), 32'(e[15:0]));
        check($sformatf("flag op%0d a%h b%h", o, a, b), 32'(bus.flag), 32'(e[18:16]));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        @(posedge CLK); #1;
        check("done_single_pulse", 32'(bus.done), 32'd0);
        check("result_held", 32'(bus.result), 32'(e[15:0]));
    endtask

    initial begin
        logic [18:0] e;
        int lat, dones, w;
        bus.start = 1'b0; bus.op = 4'd0; bus.a_data = 16'd0; bus.b_data = 16'd0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flag", 32'(bus.flag), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        RST = 1'b0;

        run_op(4'd0, 16'hFFFF, 16'h0001);
        run_op(4'd1, 16'h1010, 16'h2020);
        run_op(4'd6, 16'h8001, 16'h0001);
        run_op(4'd6, 16'h8001, 16'h0000);
        run_op(4'd7, 16'h8001, 16'h0000);
        run_op(4'd7, 16'h8001, 16'h000F);
        run_op(4'd9, 16'h0100, 16'h0100);
        run_op(4'd9, 16'hFFFF, 16'hFFFF);
        run_op(4'd9, 16'h0003, 16'h0005);
        run_op(4'd15, 16'h1234, 16'h5678);

        // start pulsed while busy must be ignored
        e = model(4'd9, 16'h0100, 16'h0100);
        w = MUL_EN ? 4 : 0;
        @(negedge CLK);
        bus.start = 1'b1; bus.op = 4'd9; bus.a_data = 16'h0100; bus.b_data = 16'h0100;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        lat = 0;
        repeat (w) begin @(posedge CLK); #1; lat++; end
        bus.start = 1'b1; bus.op = 4'd0; bus.a_data = 16'h1234; bus.b_data = 16'h1111;
        while (!bus.done && lat < 40) begin
            @(posedge CLK); #1;
            bus.start = 1'b0;
            lat++;
        end
        check("ignore_latency", lat, exp_lat(4'd9));
        check("ignore_result", 32'(bus.result), 32'(e[15:0]));
        check("ignore_flag", 32'(bus.flag), 32'(e[18:16]));
        dones = 0;
        repeat (25) begin @(posedge CLK); #1; dones += int'(bus.done); end
        check("ignore_no_extra_done", dones, 0);

        // reset aborts an in-flight op
        run_op(4'd0, 16'h1234, 16'h1111);
        w = MUL_EN ? 7 : 0;
        @(negedge CLK);
        bus.start = 1'b1; bus.op = 4'd9; bus.a_data = 16'h00FF; bus.b_data = 16'h0F0F;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        repeat (w) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_flag", 32'(bus.flag), 32'd0);
        dones = int'(bus.done);
        repeat (25) begin @(posedge CLK); #1; dones += int'(bus.done); end
        check("abort_no_done", dones, 0);
        run_op(4'd2, 16'hF0F0, 16'h0FF0);

        // back-to-back: start held through the done cycle
        @(negedge CLK);
        bus.start = 1'b1; bus.op = 4'd12; bus.a_data = 16'hAAAA; bus.b_data = 16'h5555;
        @(posedge CLK); #1;
        check("b2b_busy1", 32'(bus.busy), 32'd1);
        @(posedge CLK); #1;
        check("b2b_done1", 32'(bus.done), 32'd1);
        check("b2b_result1", 32'(bus.result), 32'd0);
        check("b2b_flag1", 32'(bus.flag), 32'b001);
        bus.op = 4'd0; bus.a_data = 16'h0001; bus.b_data = 16'h0002;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        check("b2b_gap_done", 32'(bus.done), 32'd0);
        check("b2b_busy2", 32'(bus.busy), 32'd1);
        @(posedge CLK); #1;
        check("b2b_done2", 32'(bus.done), 32'd1);
        check("b2b_result2", 32'(bus.result), 32'h0003);
        check("b2b_flag2", 32'(bus.flag), 32'b000);

        for (int i = 0; i < 40; i++)
            run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        for (int i = 0; i < 16; i++)
            run_op(4'($urandom_range(6, 7)), 16'($urandom), 16'(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
